// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch constants and next-PC select encodings
package fetch_unit_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit_npc_sel.sv
// rtl/fetch_unit_npc_sel.sv - next-PC mux, word alignment, bubble gating and IM index
module npc_sel
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = fetch_unit_pkg::PC_RESET,
  parameter int          IM_AWIDTH = 10
) (
  input  logic [31:0]          pc_f,
  input  logic                 valid_d,
  input  logic [1:0]           npc_op,
  input  logic [31:0]          branch_a,
  input  logic [31:0]          jump_a,
  input  logic [31:0]          reg_a,
  output logic [31:0]          npc,
  output logic [31:0]          pc_plus8,
  output logic [IM_AWIDTH-1:0] im_addr
);

  logic [31:0] pc_plus4;
  logic [31:0] npc_raw;
  logic [31:0] im_offset;

  always_comb begin
    pc_plus4 = pc_f + 32'd4;
    pc_plus8 = pc_f + 32'd8;
    npc_raw  = pc_plus4;
    // A bubble in ID carries no decoded redirect, so its NPCOp is meaningless.
    if (valid_d) begin
      case (npc_op_e'(npc_op))
        NPC_SEQ: npc_raw = pc_plus4;
        NPC_BR:  npc_raw = branch_a;
        NPC_J:   npc_raw = jump_a;
        NPC_JR:  npc_raw = reg_a & WORD_MASK;
        default: npc_raw = pc_plus4;
      endcase
    end
    npc       = npc_raw & WORD_MASK;
    im_offset = (pc_f - PC_RESET) >> 2;
    im_addr   = IM_AWIDTH'(im_offset);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and IF/ID pipeline register
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = fetch_unit_pkg::PC_RESET,
  parameter int          IM_AWIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Stall,
  input  logic [1:0]           NPCOp,
  input  logic [31:0]          BranchA,
  input  logic [31:0]          JumpA,
  input  logic [31:0]          RegA,
  input  logic [31:0]          InstrF,
  output logic [31:0]          PCF,
  output logic [IM_AWIDTH-1:0] ImAddr,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PC8D,
  output logic                 ValidD
);

  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instrd_q, instrd_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc8d_q, pc8d_d;
  logic        validd_q, validd_d;
  logic [31:0] npc;
  logic [31:0] pc_plus8;

  npc_sel #(
    .PC_RESET  (PC_RESET),
    .IM_AWIDTH (IM_AWIDTH)
  ) u_npc_sel (
    .pc_f     (pcf_q),
    .valid_d  (validd_q),
    .npc_op   (NPCOp),
    .branch_a (BranchA),
    .jump_a   (JumpA),
    .reg_a    (RegA),
    .npc      (npc),
    .pc_plus8 (pc_plus8),
    .im_addr  (ImAddr)
  );

  // No flush path: the word fetched alongside a redirect is the delay slot.
  always_comb begin
    pcf_d    = pcf_q;
    instrd_d = instrd_q;
    pcd_d    = pcd_q;
    pc8d_d   = pc8d_q;
    validd_d = validd_q;
    if (!Stall) begin
      pcf_d    = npc;
      instrd_d = InstrF;
      pcd_d    = pcf_q;
      pc8d_d   = pc_plus8;
      validd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q    <= PC_RESET;
      instrd_q <= 32'd0;
      pcd_q    <= 32'd0;
      pc8d_q   <= 32'd0;
      validd_q <= 1'b0;
    end else begin
      pcf_q    <= pcf_d;
      instrd_q <= instrd_d;
      pcd_q    <= pcd_d;
      pc8d_q   <= pc8d_d;
      validd_q <= validd_d;
    end
  end

  assign PCF    = pcf_q;
  assign InstrD = instrd_q;
  assign PCD    = pcd_q;
  assign PC8D   = pc8d_q;
  assign ValidD = validd_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic [1:0]  NPCOp;
  logic [31:0] BranchA, JumpA, RegA, InstrF;
  logic [31:0] PCF, InstrD, PCD, PC8D;
  logic [9:0]  ImAddr;
  logic        ValidD;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.PC_RESET(32'h0000_3000), .IM_AWIDTH(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .Stall   (Stall),
    .NPCOp   (NPCOp),
    .BranchA (BranchA),
    .JumpA   (JumpA),
    .RegA    (RegA),
    .InstrF  (InstrF),
    .PCF     (PCF),
    .ImAddr  (ImAddr),
    .InstrD  (InstrD),
    .PCD     (PCD),
    .PC8D    (PC8D),
    .ValidD  (ValidD)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word encodes its own index.
  assign InstrF = 32'hC000_0000 | {22'd0, ImAddr};

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] idx;
    idx = ((pc - 32'h0000_3000) >> 2) & 32'h0000_03FF;
    return 32'hC000_0000 | idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pcf, input logic [31:0] pcd,
                           input logic [31:0] instr, input logic valid);
    chk({tag, "_pcf"}, PCF, pcf);
    chk({tag, "_pcd"}, PCD, pcd);
    chk({tag, "_pc8d"}, PC8D, valid ? pcd + 32'd8 : 32'd0);
    chk({tag, "_instrd"}, InstrD, instr);
    chk({tag, "_validd"}, {31'd0, ValidD}, {31'd0, valid});
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; NPCOp = 2'd0;
    BranchA = 32'd0; JumpA = 32'd0; RegA = 32'd0;
    tick();
    chk_state("reset", 32'h3000, 32'd0, 32'd0, 1'b0);
    chk("reset_imaddr", {22'd0, ImAddr}, 32'd0);

    reset = 1'b0;
    tick();
    chk_state("seq1", 32'h3004, 32'h3000, word_at(32'h3000), 1'b1);
    tick();
    chk_state("seq2", 32'h3008, 32'h3004, word_at(32'h3004), 1'b1);
    chk("seq2_imaddr", {22'd0, ImAddr}, 32'd2);

    NPCOp = 2'd1; BranchA = 32'h3020;
    tick();
    chk_state("branch", 32'h3020, 32'h3008, word_at(32'h3008), 1'b1);
    chk("branch_imaddr", {22'd0, ImAddr}, 32'd8);

    NPCOp = 2'd2; JumpA = 32'h3100; Stall = 1'b1;
    tick();
    chk_state("stall1", 32'h3020, 32'h3008, word_at(32'h3008), 1'b1);
    tick();
    chk_state("stall2", 32'h3020, 32'h3008, word_at(32'h3008), 1'b1);
    Stall = 1'b0;
    tick();
    chk_state("jump", 32'h3100, 32'h3020, word_at(32'h3020), 1'b1);

    NPCOp = 2'd3; RegA = 32'h0000_3047;
    tick();
    chk_state("jr", 32'h3044, 32'h3100, word_at(32'h3100), 1'b1);

    RegA = 32'hFFFF_FFFF;
    tick();
    chk("jr_top_pcf", PCF, 32'hFFFF_FFFC);
    chk("jr_top_imaddr", {22'd0, ImAddr}, 32'h0000_03FF);

    NPCOp = 2'd0;
    tick();
    chk_state("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'hC000_03FF, 1'b1);
    chk("wrap_pc8d_mod", PC8D, 32'h0000_0004);
    chk("wrap_imaddr", {22'd0, ImAddr}, 32'h0000_0000);

    NPCOp = 2'd2; JumpA = 32'h3012;
    tick();
    chk("jmask_pcf", PCF, 32'h3010);

    Stall = 1'b1; NPCOp = 2'd1; BranchA = 32'h3502; reset = 1'b1;
    tick();
    chk_state("rst_stall", 32'h3000, 32'd0, 32'd0, 1'b0);

    reset = 1'b0; Stall = 1'b0;
    tick();
    chk_state("bubble_br", 32'h3004, 32'h3000, word_at(32'h3000), 1'b1);
    tick();
    chk("br_masked_pcf", PCF, 32'h3500);
    chk("br_masked_pcd", PCD, 32'h3004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
